psa_simd_pipe: RTL

Parametrised, pipelined successor to the 16-bit partitioned sub-word adder. It adds or subtracts two WIDTH-bit operands as independent signed lanes. The lane size is selected at run time, and each lane either saturates or wraps. The block sits behind the execute-stage operand muxes as a 2-stage, valid/ready pipelined SIMD unit. Per-lane overflow flags are reported with each result and accumulated in a sticky error register.

---
 rtl/psa_simd_pipe.sv | 132 +++++++++++++
 1 files changed

// File: rtl/psa_simd_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | psa_simd_pipe: 2-stage valid/ready SIMD add/sub, run-time lane width,     |
// | per-lane saturate/wrap, per-slot overflow flags, sticky error register.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module psa_simd_pipe #(
  parameter int WIDTH  = 16,
  parameter int LANE_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          a,
  input  logic [WIDTH-1:0]          b,
  input  logic                      sub,
  input  logic                      sat,
  input  logic [1:0]                mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          sum,
  output logic [WIDTH/LANE_W-1:0]   ovf,
  output logic [WIDTH/LANE_W-1:0]   err_sticky,
  input  logic                      clr_err
);

  localparam int NLANE = WIDTH / LANE_W;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sub_q, sub_d, sat_q, sat_d;
  logic [1:0]       mode_q, mode_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [NLANE-1:0] ovf_q, ovf_d;
  logic [NLANE-1:0] err_q, err_d;

  logic             s2_load;
  logic             accept;

  // One arithmetic slice per mode; the S1 mode register picks which one is used.
  logic [3:0][WIDTH-1:0] lane_sum;
  logic [3:0][NLANE-1:0] lane_ovf;

  for (genvar m = 0; m < 4; m++) begin : g_mode
    localparam int LW    = ((LANE_W << m) > WIDTH) ? WIDTH : (LANE_W << m);
    localparam int SLOTS = LW / LANE_W;
    for (genvar j = 0; j < WIDTH / LW; j++) begin : g_lane
      logic [LW-1:0] op_a, op_b, raw, res;
      logic          lane_o;
      assign op_a   = a_q[j*LW +: LW];
      assign op_b   = b_q[j*LW +: LW] ^ {LW{sub_q}};
      assign raw    = op_a + op_b + {{(LW-1){1'b0}}, sub_q};
      assign lane_o = (op_a[LW-1] == op_b[LW-1]) && (raw[LW-1] != op_a[LW-1]);
      // Saturate toward the sign of A: positive overflow -> max, negative -> min.
      assign res    = (sat_q && lane_o) ? {op_a[LW-1], {(LW-1){~op_a[LW-1]}}} : raw;
      assign lane_sum[m][j*LW +: LW]       = res;
      assign lane_ovf[m][j*SLOTS +: SLOTS] = {SLOTS{lane_o}};
    end
  end

  always_comb begin
    s2_load    = !s2_valid_q || out_ready;
    in_ready   = !rst && (!s1_valid_q || s2_load);
    accept     = in_valid && in_ready;

    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    sub_d      = sub_q;
    sat_d      = sat_q;
    mode_d     = mode_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      a_d        = a;
      b_d        = b;
      sub_d      = sub;
      sat_d      = sat;
      mode_d     = mode;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
    sum_d      = sum_q;
    ovf_d      = ovf_q;
    if (s2_load && s1_valid_q) begin
      sum_d = lane_sum[mode_q];
      ovf_d = lane_ovf[mode_q];
    end

    // Clear first, then OR in the delivered flags so a same-cycle event survives.
    err_d = clr_err ? '0 : err_q;
    if (s2_valid_q && out_ready) begin
      err_d = err_d | ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sub_q      <= 1'b0;
      sat_q      <= 1'b0;
      mode_q     <= 2'd0;
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      ovf_q      <= '0;
      err_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sub_q      <= sub_d;
      sat_q      <= sat_d;
      mode_q     <= mode_d;
      s2_valid_q <= s2_valid_d;
      sum_q      <= sum_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign sum        = sum_q;
  assign ovf        = ovf_q;
  assign err_sticky = err_q;

endmodule
`default_nettype wire
